// File: rtl/usbf_ssram_arb_if.sv
// Request/response and SSRAM bus bundle for usbf_ssram_arb.
// slave = arbiter side; master = requesters plus the SSRAM itself.
interface usbf_ssram_arb_if #(
  parameter int SSRAM_HADR = 14
);
  logic                  u_req_i;
  logic                  u_we_i;
  logic [SSRAM_HADR:0]   u_adr_i;
  logic [31:0]           u_din_i;
  logic [31:0]           u_dout_o;
  logic                  u_ack_o;

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [SSRAM_HADR:0]   wb_adr_i;
  logic [31:0]           wb_din_i;
  logic [31:0]           wb_dout_o;
  logic                  wb_ack_o;

  logic [SSRAM_HADR:0]   sram_adr_o;
  logic [31:0]           sram_dout_o;
  logic [31:0]           sram_din_i;
  logic                  sram_we_o;
  logic                  sram_re_o;

  modport slave (
    input  u_req_i, u_we_i, u_adr_i, u_din_i,
    output u_dout_o, u_ack_o,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_din_i,
    output wb_dout_o, wb_ack_o,
    output sram_adr_o, sram_dout_o, sram_we_o, sram_re_o,
    input  sram_din_i
  );

  modport master (
    output u_req_i, u_we_i, u_adr_i, u_din_i,
    input  u_dout_o, u_ack_o,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_din_i,
    input  wb_dout_o, wb_ack_o,
    input  sram_adr_o, sram_dout_o, sram_we_o, sram_re_o,
    output sram_din_i
  );
endinterface

// File: rtl/usbf_ssram_arb.sv
// Single-port SSRAM arbiter: USB engine (U, pipelined, high priority) vs Wishbone (W).
// Define USBF_ARB_FAIR_EN to force a W grant after MAX_STALL consecutive U grants.
module usbf_ssram_arb #(
  parameter int SSRAM_HADR = 14,
  parameter int MAX_STALL  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  usbf_ssram_arb_if.slave bus
);
  logic                grant_u;
  logic                grant_w;
  logic                w_req;
  logic                w_block;
  logic                w_turn;
  logic                u_ack;
  logic                wb_ack;
  logic                we_mux;
  logic [SSRAM_HADR:0] adr_mux;
  logic [31:0]         dout_mux;

  // w_block masks the W strobe during its own ack cycle so a held stb does not re-issue.
  assign w_req = bus.wb_cyc_i & bus.wb_stb_i & ~w_block;

`ifdef USBF_ARB_FAIR_EN
  localparam int                 STALL_W   = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL);

  logic [STALL_W-1:0] stall_cnt;

  assign w_turn = w_req & (stall_cnt == STALL_LIM);

  always_ff @(posedge clk_i) begin
    if (!rst_i || grant_w || !w_req) begin
      stall_cnt <= '0;
    end else if (grant_u) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign w_turn = 1'b0;
`endif

  always_comb begin
    grant_u = 1'b0;
    grant_w = 1'b0;
    if (rst_i) begin
      if (w_req && (!bus.u_req_i || w_turn)) begin
        grant_w = 1'b1;
      end else if (bus.u_req_i) begin
        grant_u = 1'b1;
      end
    end
  end

  // Idle cycles park the SSRAM bus on the U port values.
  always_comb begin
    adr_mux  = bus.u_adr_i;
    dout_mux = bus.u_din_i;
    we_mux   = bus.u_we_i;
    if (grant_w) begin
      adr_mux  = bus.wb_adr_i;
      dout_mux = bus.wb_din_i;
      we_mux   = bus.wb_we_i;
    end
  end

  assign bus.sram_adr_o  = adr_mux;
  assign bus.sram_dout_o = dout_mux;
  assign bus.sram_we_o   = (grant_u | grant_w) & we_mux;
  assign bus.sram_re_o   = (grant_u | grant_w) & ~we_mux;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      u_ack   <= 1'b0;
      wb_ack  <= 1'b0;
      w_block <= 1'b0;
    end else begin
      u_ack   <= grant_u;
      wb_ack  <= grant_w;
      w_block <= grant_w;
    end
  end

  assign bus.u_ack_o   = u_ack;
  assign bus.wb_ack_o  = wb_ack;
  assign bus.u_dout_o  = bus.sram_din_i;
  assign bus.wb_dout_o = bus.sram_din_i;
endmodule

// File: doc/usbf_ssram_arb.md
Name: usbf_ssram_arb

Overview:
- Two-port arbiter and sequencer in front of the single-port USB buffer SSRAM.
- Shares the SSRAM between the USB protocol/DMA engine (the "U" port, high priority) and the host Wishbone slave (the "W" port).
- Drives the SSRAM address, write data, write-enable and read-enable signals.
- Returns a one-cycle ack and the registered read data to whichever requester was served.

Parameters:
- SSRAM_HADR, 14, SSRAM address MSB index; every address bus is SSRAM_HADR+1 bits.
- MAX_STALL, 4, consecutive U grants tolerated while W waits. Used only with USBF_ARB_FAIR_EN.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-low reset
- u_req_i  in  1  U port access request (level)
- u_we_i  in  1  U port write (1) / read (0)
- u_adr_i  in  SSRAM_HADR+1  U port word address
- u_din_i  in  32  U port write data
- u_dout_o  out  32  U port read data, valid in the u_ack_o cycle
- u_ack_o  out  1  U port access done, one-cycle pulse
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  SSRAM_HADR+1  Wishbone word address
- wb_din_i  in  32  Wishbone write data
- wb_dout_o  out  32  Wishbone read data, valid in the wb_ack_o cycle
- wb_ack_o  out  1  Wishbone ack, one-cycle pulse
- sram_adr_o  out  SSRAM_HADR+1  to SSRAM address
- sram_dout_o  out  32  to SSRAM write data
- sram_din_i  in  32  from SSRAM registered read data
- sram_we_o  out  1  to SSRAM write enable
- sram_re_o  out  1  to SSRAM read enable

Behaviour:
- W request is defined as w_req = wb_cyc_i & wb_stb_i & ~w_block.
- Grant, evaluated combinationally each cycle:
  - u_req_i=1: U is granted.
  - u_req_i=0 and w_req=1: W is granted.
  - Neither: idle.
  - U wins any simultaneous request, unless the optional feature overrides it.
- SSRAM drive, combinational from the grant:
  - Granted port: sram_adr_o/sram_dout_o take that port's address/data; sram_we_o = port we; sram_re_o = ~port we.
  - Idle: sram_we_o=0, sram_re_o=0; sram_adr_o/sram_dout_o hold the U port values.
  - sram_we_o and sram_re_o are never both 1.
- Latency: a grant at cycle N gives the ack at N+1.
  - u_ack_o/wb_ack_o are registered from grant_u/grant_w.
  - Read data appears on sram_din_i at N+1.
  - u_dout_o = wb_dout_o = sram_din_i (direct wire).
  - Write ack timing is the same as read ack timing.
- U port is pipelined: u_req_i held high gives a grant every cycle and u_ack_o every cycle. The requester updates address/data after each ack.
- W port handshake:
  - w_block is a register set on the cycle W is granted; it is therefore high during the wb_ack_o cycle, then clears.
  - This prevents the still-asserted stb from re-issuing the access.
  - Minimum W spacing is 2 cycles.
- W abort: wb_cyc_i deasserted after grant still produces wb_ack_o (the access has already happened); the master ignores it.
- Reset (rst_i=0 at a clock edge):
  - u_ack_o=0, wb_ack_o=0, w_block=0, stall counter=0.
  - sram_we_o/sram_re_o forced 0 while rst_i=0.
  - An in-flight ack is dropped; the requester must reissue.
- Read-after-write to the same address, back-to-back from U (write at N, read at N+1): the read returns the new data, since the SSRAM write completes at edge N+1.

Optional Feature:
- Macro: USBF_ARB_FAIR_EN.
- Defined:
  - A stall counter (width clog2(MAX_STALL+1)) increments each cycle that w_req=1 and U is granted.
  - It clears whenever W is granted or w_req=0.
  - When the counter equals MAX_STALL, W is granted over a pending U. U then waits that cycle (no u_ack_o next cycle).
- Undefined: strict U priority; the counter logic is absent; W can starve indefinitely.

Test Plan:
- Reset held for 3 cycles with u_req_i=1, wb_stb_i=1 -> sram_we_o=sram_re_o=0, no acks; first grant occurs in the cycle after rst_i rises.
- U write 0xDEADBEEF @0x0010, then U read @0x0010 back-to-back -> u_ack_o at N+1 and N+2; u_dout_o=0xDEADBEEF at N+2.
- W read @0x0020 (preloaded 0x12345678), stb held until ack -> wb_ack_o exactly 1 cycle after grant, wb_dout_o=0x12345678, no second SSRAM access in the ack cycle.
- U and W request in the same cycle -> U granted first; W granted the first cycle u_req_i=0; each ack arrives exactly 1 cycle after its grant.
- USBF_ARB_FAIR_EN, MAX_STALL=4, u_req_i held continuously, W read pending -> 4 U grants, then 1 W grant (wb_ack_o), then U resumes; without the macro, W is never acked.
- W write with wb_cyc_i dropped the cycle after grant -> SSRAM written once, single wb_ack_o pulse, no further W grant.
